alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Multi-cycle ALU execution stage. It consumes the 4-bit ALUControl code from the ALU
//   decoder, plus the two source operands. Add/sub/logic/compare/lui complete in 1 cycle.
//   Shifts are iterative, at SHIFT_STEP bits per cycle, to cut area versus a barrel shifter.
//   Valid/ready handshakes sit on both sides, so the block can drop into a multi-cycle or
//   stalled datapath.
// PARAMETERS
//   WIDTH       32  operand/result width; must be a power of 2, >= 8
//   SHIFT_STEP  1   max bit positions shifted per cycle; 1 <= SHIFT_STEP <= WIDTH-1
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   valid_i     in   1      request valid
//   ready_o     out  1      block can accept a request (high only in IDLE)
//   ALUControl  in   4      operation code, latched at accept
//   SrcA        in   WIDTH  operand A, latched at accept
//   SrcB        in   WIDTH  operand B; shamt = SrcB[$clog2(WIDTH)-1:0]
//   valid_o     out  1      ALUResult/Zero valid (high only in DONE)
//   ready_i     in   1      consumer accepts result
//   ALUResult   out  WIDTH  result, held stable while valid_o=1
//   Zero        out  1      ALUResult == 0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; ALUResult=0; Zero=1; valid_o=0; ready_o=1 after release.
//   Codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed),
//     0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 lui (result=SrcB).
//     1011-1111 illegal: result 0, 1-cycle path.
//   Arithmetic: add/sub are modulo 2^WIDTH, carry dropped; slt/sltu return 1 or 0, zero-extended.
//   Accept occurs at a rising edge with valid_i & ready_o. valid_i while ready_o=0 is ignored
//     (no queueing). Operands and code are captured at accept; later input changes have no effect.
//   FSM: IDLE -> DONE at accept, for non-shift ops or any shift with shamt=0 (result = op(SrcA,SrcB)).
//     IDLE -> SHIFT at accept, for a shift with shamt=n>0: acc<=SrcA, cnt<=n.
//     SHIFT: each edge shifts acc by k=min(SHIFT_STEP,cnt) and sets cnt<=cnt-k.
//       sll fills 0; srl fills 0; sra fills acc[WIDTH-1] (the original sign).
//       The edge where cnt reaches 0 moves to DONE with ALUResult=shifted acc.
//     DONE: valid_o=1; outputs held; on an edge with ready_i=1 -> IDLE.
//   Latency: accept edge to first cycle with valid_o=1 is 1 edge for 1-cycle ops.
//     For shifts it is 1+ceil(n/SHIFT_STEP) edges.
//   Throughput: ready_o=0 in SHIFT and DONE, so back-to-back requests need >= 1 IDLE cycle.
//   Backpressure: ready_i may stay low indefinitely; ALUResult, Zero and valid_o stay constant.
//   Zero is registered together with ALUResult, so it always matches the presented result.
//   Reset mid-operation: the in-flight op is dropped, outputs take reset values, no valid_o pulse.
//   ALUResult in IDLE/SHIFT holds the last completed result (0 after reset) and is don't-care to consumers.
//   Valid/ready outputs are registered or decoded only from state; no combinational in->out path.
// TESTING
//   1 add: SrcA=5, SrcB=7, code 0000 -> valid_o 1 edge after accept, ALUResult=12, Zero=0.
//   2 sub equal: SrcA=SrcB=0x1234, code 0001 -> ALUResult=0, Zero=1; the same op cycle can feed branch logic.
//   3 sra: SrcA=0x80000000, SrcB=31, SHIFT_STEP=1 -> ALUResult=0xFFFFFFFF, valid_o 32 edges after accept.
//     With SHIFT_STEP=4 -> 9 edges; srl of the same operands -> 0x00000001.
//   4 slt/sltu: SrcA=0xFFFFFFFF, SrcB=1 -> slt=1, sltu=0. Code 1011 -> ALUResult=0 after 1 edge.
//   5 backpressure: hold ready_i=0 for 10 cycles in DONE.
//     -> outputs stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next edge.
//   6 reset mid-shift: assert rst_n=0 at edge 5 of a 31-bit sll.
//     -> immediately valid_o=0, ALUResult=0, Zero=1; after release a new add completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU stage with single-cycle arithmetic/logic and iterative shifts behind valid/ready handshakes
module alu_seq #(
   parameter int WIDTH      = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d, alu, shifted, sra_v;
   logic [SW-1:0]    cnt_q, cnt_d, k, shamt;
   logic             zero_q, zero_d, is_shift;
   assign ready_o   = state_q == IDLE;
   assign valid_o   = state_q == DONE;
   assign ALUResult = res_q;
   assign Zero      = zero_q;
   assign shamt     = SrcB[SW-1:0];
   assign is_shift  = ALUControl inside {4'b0110, 4'b0111, 4'b1000};
   assign k         = (cnt_q < SW'(SHIFT_STEP)) ? cnt_q : SW'(SHIFT_STEP);
   assign sra_v     = $signed(acc_q) >>> k;
   // single-cycle result; shifts only land here with shamt 0, so they pass SrcA through
   always_comb begin
      case (ALUControl)
         4'b0000: alu = SrcA + SrcB;
         4'b0001: alu = SrcA - SrcB;
         4'b0010: alu = SrcA & SrcB;
         4'b0011: alu = SrcA | SrcB;
         4'b0100: alu = SrcA ^ SrcB;
         4'b0101: alu = WIDTH'($signed(SrcA) < $signed(SrcB));
         4'b0110, 4'b0111, 4'b1000: alu = SrcA;
         4'b1001: alu = WIDTH'(SrcA < SrcB);
         4'b1010: alu = SrcB;
         default: alu = '0;
      endcase
   end
   // one shift step of at most SHIFT_STEP positions on the accumulator
   always_comb begin
      shifted = op_q == 4'b0110 ? acc_q << k : op_q == 4'b0111 ? acc_q >> k : sra_v;
   end
   // next-state logic: accept in IDLE, iterate in SHIFT, hold in DONE until consumed
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
      if (state_q == IDLE && valid_i) begin
         if (is_shift && shamt != '0) begin
            state_d = SHIFT;
            op_d    = ALUControl;
            acc_d   = SrcA;
            cnt_d   = shamt;
         end else begin
            state_d = DONE;
            res_d   = alu;
            zero_d  = alu == '0;
         end
      end else if (state_q == SHIFT) begin
         acc_d = shifted;
         cnt_d = cnt_q - k;
         if (cnt_q == k) begin
            state_d = DONE;
            res_d   = shifted;
            zero_d  = shifted == '0;
         end
      end else if (state_q == DONE && ready_i) begin
         state_d = IDLE;
      end
   end
   // state and datapath registers; reset drops any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a one-shot arithmetic reference model
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  valid_i = '0;
   logic [1:0]  ready_i = '0;
   wire  [1:0]  ready_o, valid_o, zero;
   logic [3:0]  code [2] = '{4'd0, 4'd0};
   logic [31:0] a [2] = '{32'd0, 32'd0};
   logic [31:0] b [2] = '{32'd0, 32'd0};
   wire  [31:0] res [2];
   int          n_cmp = 0;
   int          n_err = 0;
   always #5 clk = ~clk;
   alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
      .ALUControl(code[0]), .SrcA(a[0]), .SrcB(b[0]), .valid_o(valid_o[0]),
      .ready_i(ready_i[0]), .ALUResult(res[0]), .Zero(zero[0]));
   alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
      .ALUControl(code[1]), .SrcA(a[1]), .SrcB(b[1]), .valid_o(valid_o[1]),
      .ready_i(ready_i[1]), .ALUResult(res[1]), .Zero(zero[1]));
   function automatic int step(int d);
      return d == 0 ? 1 : 4;
   endfunction
   function automatic logic [31:0] model(logic [3:0] c, logic [31:0] x, logic [31:0] y);
      logic signed [31:0] sx;
      int sh;
      sx = x;
      sh = int'(y[4:0]);
      case (c)
         4'd0:    return x + y;
         4'd1:    return x - y;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return x ^ y;
         4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6:    return x << sh;
         4'd7:    return x >> sh;
         4'd8:    return sx >>> sh;
         4'd9:    return (x < y) ? 32'd1 : 32'd0;
         4'd10:   return y;
         default: return 32'd0;
      endcase
   endfunction
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one complete transaction on DUT d; entered and left #1 after a rising edge
   task automatic do_op(int d, logic [3:0] c, logic [31:0] sa, logic [31:0] sb, int hold);
      logic [31:0] er;
      int sh, el, lat;
      er = model(c, sa, sb);
      sh = int'(sb[4:0]);
      el = (c inside {4'd6, 4'd7, 4'd8} && sh != 0) ? 1 + (sh + step(d) - 1) / step(d) : 1;
      check("ready_idle", ready_o[d], 1);
      valid_i[d] = 1'b1;
      code[d] = c;
      a[d] = sa;
      b[d] = sb;
      @(posedge clk);
      #1;
      valid_i[d] = 1'b0;
      code[d] = 4'($urandom);
      a[d] = $urandom;
      b[d] = $urandom;
      lat = 1;
      while (!valid_o[d] && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, el);
      check("result", res[d], er);
      check("zero", zero[d], er == 0);
      for (int i = 0; i < hold; i++) begin
         valid_i[d] = 1'b1;
         @(posedge clk);
         #1;
         check("hold_result", res[d], er);
         check("hold_valid", valid_o[d], 1);
         check("hold_ready", ready_o[d], 0);
      end
      valid_i[d] = 1'b0;
      ready_i[d] = 1'b1;
      @(posedge clk);
      #1;
      ready_i[d] = 1'b0;
      check("release_valid", valid_o[d], 0);
      check("release_ready", ready_o[d], 1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_valid", valid_o[d], 0);
         check("rst_result", res[d], 0);
         check("rst_zero", zero[d], 1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_op(0, 4'd0, 32'd5, 32'd7, 0);
      do_op(0, 4'd1, 32'h1234, 32'h1234, 0);
      do_op(0, 4'd8, 32'h8000_0000, 32'd31, 0);
      do_op(1, 4'd8, 32'h8000_0000, 32'd31, 0);
      do_op(1, 4'd7, 32'h8000_0000, 32'd31, 0);
      do_op(1, 4'd6, 32'h0000_0003, 32'd7, 1);
      do_op(0, 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(0, 4'd9, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(0, 4'd11, 32'hDEAD_BEEF, 32'd1, 0);
      do_op(0, 4'd7, 32'hABCD_0123, 32'h40, 0);
      do_op(0, 4'd0, 32'd3, 32'd4, 10);
      valid_i[0] = 1'b1;
      code[0] = 4'd6;
      a[0] = 32'd1;
      b[0] = 32'd31;
      @(posedge clk);
      #1;
      valid_i[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", valid_o[0], 0);
      check("midrst_result", res[0], 0);
      check("midrst_zero", zero[0], 1);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("midrst_novalid", valid_o[0], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_op(0, 4'd0, 32'd100, 32'd23, 0);
      for (int i = 0; i < 60; i++)
         do_op(i % 2, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
